flip_candidate_sequencer: RTL

- Upstream feeder for the per-clause temporal buffer array.
- Accepts one selected unsatisfied clause of NSAT literals.
- For each candidate flip in the clause, in order (index 0..NSAT-1):
  - inverts that literal;
  - reads its occurrence list from the clause-table memory;
  - presents the flipped literal, replicated per occurrence slot, with the occurrence-list literals on the temporal-buffer write bus, tagged with write_index.
- Signals done once all NSAT candidates have been written.

---
 rtl/flip_candidate_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/flip_candidate_sequencer.sv
// Walks the NSAT literals of a selected clause, fetches each variable's occurrence list and emits
// one flipped-literal write per candidate. Optional macro FLIP_SEQ_SKIP_EMPTY_EN skips empty literals.
module flip_candidate_sequencer #(
  parameter int NSAT                     = 3,
  parameter int LITERAL_ADDRESS_WIDTH    = 11,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NSAT_BITS                = 2,
  parameter int MEM_LATENCY              = 2
) (
  input  logic                                                            clk,
  input  logic                                                            reset,
  input  logic                                                            clause_valid_i,
  output logic                                                            clause_ready_o,
  input  logic [NSAT*(LITERAL_ADDRESS_WIDTH+1)-1:0]                       clause_i,
  output logic                                                            occ_rd_en_o,
  output logic [LITERAL_ADDRESS_WIDTH-1:0]                                occ_addr_o,
  input  logic [MAX_CLAUSES_PER_VARIABLE*(NSAT-1)*(LITERAL_ADDRESS_WIDTH+1)-1:0] occ_rdata_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0]                             occ_mask_i,
  output logic                                                            tb_write_en_o,
  output logic [NSAT_BITS-1:0]                                            write_index_o,
  output logic [MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)-1:0]   flipped_literal_multi_o,
  output logic [MAX_CLAUSES_PER_VARIABLE*(NSAT-1)*(LITERAL_ADDRESS_WIDTH+1)-1:0] clause_table_literals_multi_o,
  output logic                                                            done_o
);
  localparam int LW    = LITERAL_ADDRESS_WIDTH + 1;
  localparam int OW    = (NSAT - 1) * LW;
  localparam int MS    = MAX_CLAUSES_PER_VARIABLE;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NSAT_BITS-1:0] index_q, index_d;
  logic [NSAT*LW-1:0]   clause_q, clause_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [MS*LW-1:0]     flipped_q, flipped_d;
  logic [MS*OW-1:0]     table_q, table_d;

  logic [LW-1:0]        clause_lits [NSAT];
  logic [LW-1:0]        cur_lit;
  logic [NSAT_BITS-1:0] next_index;

  genvar gi;
  generate
    for (gi = 0; gi < NSAT; gi++) begin : g_lit
      assign clause_lits[gi] = clause_q[gi*LW +: LW];
    end
  endgenerate

  assign cur_lit    = clause_lits[index_q];
  assign next_index = index_q + NSAT_BITS'(1);

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    clause_d   = clause_q;
    wait_cnt_d = wait_cnt_q;
    flipped_d  = flipped_q;
    table_d    = table_q;
    case (state_q)
      S_IDLE: begin
        if (clause_valid_i) begin
          clause_d = clause_i;
          index_d  = '0;
          state_d  = S_ISSUE;
`ifdef FLIP_SEQ_SKIP_EMPTY_EN
          if (clause_i[LITERAL_ADDRESS_WIDTH-1:0] == '0) begin
            state_d   = S_WRITE;
            flipped_d = '0;
            table_d   = '0;
          end
`endif
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
          state_d   = S_WRITE;
          flipped_d = '0;
          table_d   = '0;
          // Only occupied occurrence slots carry data; the rest are forced to zero.
          for (int s = 0; s < MS; s++) begin
            if (occ_mask_i[s]) begin
              flipped_d[s*LW +: LW] = {~cur_lit[LW-1], cur_lit[LW-2:0]};
              table_d[s*OW +: OW]   = occ_rdata_i[s*OW +: OW];
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (index_q == NSAT_BITS'(NSAT - 1)) begin
          state_d = S_DONE;
        end else begin
          index_d = next_index;
          state_d = S_ISSUE;
`ifdef FLIP_SEQ_SKIP_EMPTY_EN
          if (clause_lits[next_index][LITERAL_ADDRESS_WIDTH-1:0] == '0) begin
            state_d   = S_WRITE;
            flipped_d = '0;
            table_d   = '0;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      clause_q   <= '0;
      wait_cnt_q <= '0;
      flipped_q  <= '0;
      table_q    <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      clause_q   <= clause_d;
      wait_cnt_q <= wait_cnt_d;
      flipped_q  <= flipped_d;
      table_q    <= table_d;
    end
  end

  assign clause_ready_o                = (state_q == S_IDLE);
  assign occ_rd_en_o                   = (state_q == S_ISSUE);
  assign occ_addr_o                    = cur_lit[LITERAL_ADDRESS_WIDTH-1:0];
  assign tb_write_en_o                 = (state_q == S_WRITE);
  assign write_index_o                 = index_q;
  assign flipped_literal_multi_o       = flipped_q;
  assign clause_table_literals_multi_o = table_q;
  assign done_o                        = (state_q == S_DONE);

endmodule
